// File: rtl/enc_code_fifo_pkg.sv
// Shared definitions for the 4-input priority encoder and its consumers.
// Code constants map the highest-priority set D bit to the encoder's Y output.
package enc_pkg;

    localparam int CODE_W = 2;

    typedef logic [CODE_W-1:0] enc_code_t;

    localparam enc_code_t CODE_D0 = 2'b11;
    localparam enc_code_t CODE_D1 = 2'b10;
    localparam enc_code_t CODE_D2 = 2'b01;
    localparam enc_code_t CODE_D3 = 2'b00;

endpackage

// File: rtl/enc_code_fifo_if.sv
// Encoder-side input and consumer-side ready/valid bundle for enc_code_fifo.
// The drop_cnt signal only exists when ENC_FIFO_DROP_CNT_EN is defined.
interface enc_code_fifo_if
    import enc_pkg::*;
    #(parameter int DEPTH = 4)
    ();

    logic                     enc_valid;
    enc_code_t                enc_Y;
    logic                     out_ready;
    logic                     out_valid;
    enc_code_t                out_code;
    logic [$clog2(DEPTH):0]   level;
    logic                     full;
    logic                     empty;
    logic                     overflow;
`ifdef ENC_FIFO_DROP_CNT_EN
    logic [7:0]               drop_cnt;

    modport slave  (input  enc_valid, enc_Y, out_ready,
                    output out_valid, out_code, level, full, empty, overflow, drop_cnt);
    modport master (output enc_valid, enc_Y, out_ready,
                    input  out_valid, out_code, level, full, empty, overflow, drop_cnt);
`else
    modport slave  (input  enc_valid, enc_Y, out_ready,
                    output out_valid, out_code, level, full, empty, overflow);
    modport master (output enc_valid, enc_Y, out_ready,
                    input  out_valid, out_code, level, full, empty, overflow);
`endif

endinterface

// File: rtl/enc_code_fifo_change_detect.sv
// Turns the encoder's level-style (valid, Y) pair into a one-cycle push request:
// fires when valid rises or when the code changes while valid stays high.
module enc_change_detect
    import enc_pkg::*;
    (
    input  logic      clk,
    input  logic      rst,
    input  logic      enc_valid,
    input  enc_code_t enc_Y,
    output logic      push_req
    );

    logic      prev_valid;
    enc_code_t prev_Y;

    // Remember last cycle's encoder output unconditionally; a dropped event is never retried.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_valid <= 1'b0;
            prev_Y     <= '0;
        end else begin
            prev_valid <= enc_valid;
            prev_Y     <= enc_Y;
        end
    end

    assign push_req = enc_valid && (!prev_valid || (enc_Y != prev_Y));

endmodule

// File: rtl/enc_code_fifo.sv
// Event FIFO behind the priority encoder: change-detected codes are queued and
// presented first-word-fall-through on a ready/valid port.
// Optional: define ENC_FIFO_DROP_CNT_EN to add the saturating drop_cnt output.
module enc_code_fifo
    import enc_pkg::*;
    #(parameter int DEPTH = 4)
    (
    input  logic                   clk,
    input  logic                   rst,
    enc_code_fifo_if.slave         bus
    );

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    enc_code_t   mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] level_i;
    logic        full_i;
    logic        empty_i;
    logic        push_req;
    logic        pop;
    logic        push;
    logic        drop;
    logic        overflow_q;

    enc_change_detect u_change_detect (
        .clk       (clk),
        .rst       (rst),
        .enc_valid (bus.enc_valid),
        .enc_Y     (bus.enc_Y),
        .push_req  (push_req)
    );

    // Extra pointer MSB makes the difference span 0..DEPTH, separating full from empty.
    assign level_i = wr_ptr - rd_ptr;
    assign full_i  = (level_i == FULL_LVL);
    assign empty_i = (level_i == '0);

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop  = !empty_i && bus.out_ready;
    assign push = push_req && (!full_i || pop);
    assign drop = push_req && full_i && !pop;

    // Storage is intentionally not reset; out_code is meaningless while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= bus.enc_Y;
        end
    end

    // Pointer advance and the one-cycle overflow pulse for a dropped event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            overflow_q <= drop;
        end
    end

`ifdef ENC_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    // Saturating count of dropped events, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

    assign bus.out_valid = !empty_i;
    assign bus.out_code  = mem[rd_ptr[AW-1:0]];
    assign bus.level     = level_i;
    assign bus.full      = full_i;
    assign bus.empty     = empty_i;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_enc_code_fifo.sv
// Scoreboard bench for enc_code_fifo: stimulus pushes hand-computed expected
// codes into a queue, a negedge monitor pops and compares on every handshake.
module tb_enc_code_fifo;
    import enc_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    enc_code_t exp_q[$];

    enc_code_fifo_if #(.DEPTH(DEPTH)) bus ();

    enc_code_fifo #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input enc_code_t y, input logic rdy);
        bus.enc_valid = v;
        bus.enc_Y     = y;
        bus.out_ready = rdy;
    endtask

    task automatic chk_state(input string name, input int lvl, input int ovf);
        chk({name, " level"}, int'(bus.level), lvl);
        chk({name, " full"}, int'(bus.full), (lvl == DEPTH) ? 1 : 0);
        chk({name, " empty"}, int'(bus.empty), (lvl == 0) ? 1 : 0);
        chk({name, " out_valid"}, int'(bus.out_valid), (lvl != 0) ? 1 : 0);
        chk({name, " overflow"}, int'(bus.overflow), ovf);
    endtask

    // Monitor: every accepted pop must match the oldest expected code.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got code %0d, expected no entry", bus.out_code);
            end else begin
                enc_code_t e;
                e = exp_q.pop_front();
                if (bus.out_code !== e) begin
                    errors++;
                    $display("FAIL pop_code: got %0d expected %0d", bus.out_code, e);
                end
            end
        end
    end

    initial begin
        drive(1'($urandom), 2'($urandom), 1'($urandom));
        #1;
        chk_state("reset", 0, 0);
`ifdef ENC_FIFO_DROP_CNT_EN
        chk("reset drop_cnt", int'(bus.drop_cnt), 0);
`endif
        repeat (3) begin
            @(posedge clk);
            drive(1'($urandom), 2'($urandom), 1'($urandom));
            #1;
            chk_state("reset_held", 0, 0);
        end
        drive(1'b0, CODE_D3, 1'b0);
        #2 rst = 1'b0;

        // Held valid with constant code: exactly one event.
        drive(1'b1, CODE_D0, 1'b0);
        exp_q.push_back(CODE_D0);
        repeat (5) tick();
        chk_state("held", 1, 0);
        chk("held out_code", int'(bus.out_code), int'(CODE_D0));
        drive(1'b0, CODE_D0, 1'b1);
        tick();
        drive(1'b0, CODE_D0, 1'b0);
        chk_state("drain1", 0, 0);

        // Fill with four distinct codes, then a fifth is dropped.
        drive(1'b1, CODE_D0, 1'b0); exp_q.push_back(CODE_D0); tick();
        drive(1'b1, CODE_D1, 1'b0); exp_q.push_back(CODE_D1); tick();
        drive(1'b1, CODE_D2, 1'b0); exp_q.push_back(CODE_D2); tick();
        drive(1'b1, CODE_D3, 1'b0); exp_q.push_back(CODE_D3); tick();
        chk_state("fill", 4, 0);
        drive(1'b1, CODE_D0, 1'b0);
        tick();
        chk_state("overflow", 4, 1);
`ifdef ENC_FIFO_DROP_CNT_EN
        chk("drop_cnt", int'(bus.drop_cnt), 1);
`endif
        tick();
        chk_state("overflow_end", 4, 0);

        drive(1'b0, CODE_D0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_state("drain4", 3 - k, 0);
        end
        drive(1'b0, CODE_D0, 1'b0);

        // Refill, then push and pop together while full.
        drive(1'b1, CODE_D0, 1'b0); exp_q.push_back(CODE_D0); tick();
        drive(1'b1, CODE_D1, 1'b0); exp_q.push_back(CODE_D1); tick();
        drive(1'b1, CODE_D2, 1'b0); exp_q.push_back(CODE_D2); tick();
        drive(1'b1, CODE_D3, 1'b0); exp_q.push_back(CODE_D3); tick();
        drive(1'b1, CODE_D1, 1'b1); exp_q.push_back(CODE_D1);
        tick();
        drive(1'b1, CODE_D1, 1'b0);
        chk_state("push_pop_full", 4, 0);
        drive(1'b0, CODE_D1, 1'b1);
        repeat (4) tick();
        drive(1'b0, CODE_D1, 1'b0);
        chk_state("drain_pp", 0, 0);

        // Valid gap with the same code gives two events.
        drive(1'b1, CODE_D1, 1'b0); exp_q.push_back(CODE_D1); tick();
        drive(1'b0, CODE_D1, 1'b0); tick();
        drive(1'b1, CODE_D1, 1'b0); exp_q.push_back(CODE_D1); tick();
        tick();
        chk_state("gap", 2, 0);
        drive(1'b1, CODE_D2, 1'b0); exp_q.push_back(CODE_D2); tick();
        chk_state("pre_reset", 3, 0);

        // Asynchronous reset mid-operation with valid held.
        #2 rst = 1'b1;
        #1;
        chk_state("async_reset", 0, 0);
        exp_q.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        exp_q.push_back(CODE_D2);
        tick();
        chk_state("post_reset", 1, 0);
        chk("post_reset out_code", int'(bus.out_code), int'(CODE_D2));
        drive(1'b0, CODE_D2, 1'b1);
        tick();
        drive(1'b0, CODE_D2, 1'b0);
        chk_state("final", 0, 0);
        chk("scoreboard empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/enc_code_fifo.md
Name: enc_code_fifo

Overview:
- Downstream consumer of the 4-input priority encoder's registered (Y, valid) pair.
- Converts the encoder's level-style output into discrete events.
  - An entry is pushed only when valid rises, or when the code changes while valid is held.
- Buffers events in a small FIFO and presents them on a ready/valid interface to the next stage (interrupt/service logic).

Parameters:
- DEPTH, 4, number of FIFO entries; power of 2, >= 2.
- CODE_W, 2, width of encoder code (matches encoder Y).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- enc_valid  input  1  encoder valid (any D bit set).
- enc_Y  input  CODE_W  encoder code (D[0] -> 2'b11, D[1] -> 2'b10, D[2] -> 2'b01, D[3] -> 2'b00).
- out_ready  input  1  consumer ready.
- out_valid  output  1  FIFO not empty.
- out_code  output  CODE_W  head-of-FIFO code.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- overflow  output  1  one-cycle pulse: an event was dropped.
- drop_cnt  output  8  saturating dropped-event count (only with ENC_FIFO_DROP_CNT_EN).

Behaviour:
- Reset (async, immediate on rst rise):
  - Cleared: rd_ptr, wr_ptr, prev_valid, prev_Y, overflow, drop_cnt.
  - Outputs: out_valid=0, empty=1, full=0, level=0, overflow=0.
  - out_code is don't-care while empty. Storage array is not reset.
- Change detect:
  - push_req = enc_valid && (!prev_valid || enc_Y != prev_Y).
  - Every cycle: prev_valid <= enc_valid, prev_Y <= enc_Y, regardless of push outcome. A dropped event is never retried.
- Pop:
  - pop = out_valid && out_ready.
  - First-word fall-through: out_code = mem[rd_ptr[$clog2(DEPTH)-1:0]], driven combinationally from registered storage.
- Pointers:
  - $clog2(DEPTH)+1 bits each; extra MSB distinguishes full from empty.
  - Increment with natural wrap.
  - level = wr_ptr - rd_ptr.
- Push accept:
  - Accepted if !full, or if full && pop in the same cycle; the entry is written at the tail.
  - Otherwise (push_req && full && !pop): entry dropped; overflow=1 for exactly the next cycle.
- Simultaneous push and pop:
  - Level unchanged.
  - Pop when empty is impossible (out_valid=0). A push into an empty FIFO appears on out_valid one cycle after the sampling edge; no same-cycle bypass.
- Latency: encoder event sampled at edge N -> out_valid/out_code valid after edge N (1 cycle).
- Flags: full, empty and out_valid derive from registered pointers only; no combinational path from inputs to outputs except out_code muxing.
- Reset mid-operation:
  - All queued events are discarded.
  - prev_valid=0 after release, so a still-asserted enc_valid pushes once on the first edge after release.

Optional Feature:
- Macro ENC_FIFO_DROP_CNT_EN.
- Defined:
  - drop_cnt port exists.
  - Increments by 1 on each dropped event; saturates at 8'hFF.
  - Cleared only by rst.
- Undefined:
  - drop_cnt port and counter are absent.
  - overflow pulse is unchanged.

Decomposition:
- Package enc_pkg holds:
  - CODE_W constant.
  - typedef enc_code_t (logic [CODE_W-1:0]).
  - Named code constants CODE_D0=2'b11, CODE_D1=2'b10, CODE_D2=2'b01, CODE_D3=2'b00, shared with the encoder and its bench.
- One natural sub-module, enc_change_detect:
  - Holds the prev_valid/prev_Y registers.
  - Outputs push_req.
  - Reusable by other consumers of the encoder.

Test Plan:
- rst=1 with random inputs -> out_valid=0, empty=1, full=0, level=0, overflow=0 immediately (before the next edge); drop_cnt=0.
- enc_valid=1, enc_Y=2'b11 held 5 cycles, out_ready=0 -> exactly one entry; level=1, out_code=2'b11.
- Fill then overflow:
  - Stimulus: codes 11, 10, 01, 00 one cycle each with valid held, out_ready=0 -> level=4, full=1.
  - Next code 11 -> overflow pulses 1 cycle, level stays 4, drop_cnt=1.
  - Then out_ready=1 -> out_code 11, 10, 01, 00 on 4 consecutive cycles, then empty=1.
- Full with push and pop in the same cycle (new code 10, out_ready=1) -> head 11 popped, 10 written at tail, level stays 4, no overflow.
- enc_valid=1 Y=10, then enc_valid=0 one cycle, then enc_valid=1 Y=10 -> two entries of 10 queued.
- rst pulsed while level=3 and enc_valid=1 Y=01 held -> out_valid=0 asynchronously. After release: one push of 01, level=1 on the following cycle.
